// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the iterative divider.
//   div_op_e    : M-extension divide opcode (DIV, DIVU, REM, REMU)
//   div_state_e : divider FSM states
//   is_signed() : true for DIV/REM
//   is_rem()    : true for REM/REMU (result is the remainder)
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    function automatic logic is_signed(input div_op_e op);
        return ~op[0];
    endfunction

    function automatic logic is_rem(input div_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// -----------------------------------------------------------------------------
// div_restore_step
// One combinational radix-2 restoring-division step on magnitudes.
//   part_rem [WIDTH:0]   : partial remainder before the step
//   next_bit             : next dividend bit shifted in at the LSB
//   divisor  [WIDTH-1:0] : divisor magnitude
//   new_rem  [WIDTH:0]   : partial remainder after the step
//   q_bit                : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   new_rem,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign shifted = {part_rem[WIDTH-1:0], next_bit};
    assign diff    = {1'b0, shifted} - {2'b00, divisor};

    // A set MSB in the incoming remainder means the shifted value already
    // exceeds any WIDTH-bit divisor, so the subtraction must succeed; the low
    // WIDTH+1 bits of the difference are still exact in that case.
    assign q_bit   = part_rem[WIDTH] | ~diff[WIDTH+1];
    assign new_rem = q_bit ? diff[WIDTH:0] : shifted;

endmodule

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
// Radix-2 iterative divider for the M-extension execute stage. Handles
// DIV/DIVU/REM/REMU on magnitudes with sign correction, with RISC-V results
// for divide-by-zero and signed overflow. Valid/ready on both sides, plus flush.
//
// Optional feature macro: DIV_RESULT_CACHE_EN
//   Keeps the last completed operands/signedness with quotient and remainder so
//   a matching follow-up request (e.g. DIV then REM) finishes in one cycle.
//
// Ports:
//   clk, rst (async, active-high)
//   flush                 : abort in-flight op, back to IDLE next edge
//   in_valid / in_ready   : request handshake (in_ready high only in IDLE)
//   op [1:0]              : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend, divisor     : operands, WIDTH bits
//   out_valid / out_ready : result handshake (out_valid held until out_ready)
//   result                : quotient or remainder per op
// -----------------------------------------------------------------------------
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state;
    div_op_e          op_q;
    logic [WIDTH-1:0] quo_q;      // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [WIDTH:0]   rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] result_q;

    // Accept-time decode of the incoming request.
    div_op_e          op_in;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] special_q;
    logic [WIDTH-1:0] special_r;
    logic             accept;

    assign op_in     = div_op_e'(op);
    assign sgn       = is_signed(op_in);
    assign a_neg     = sgn & dividend[WIDTH-1];
    assign b_neg     = sgn & divisor[WIDTH-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor : divisor;
    assign div_zero  = (divisor == '0);
    assign ovf       = sgn && (dividend == MIN_VAL) && (divisor == '1);
    assign special_q = div_zero ? '1 : MIN_VAL;
    assign special_r = div_zero ? dividend : '0;
    assign accept    = in_valid & in_ready & ~flush;

    // One shared restoring step, reused every CALC cycle.
    logic [WIDTH:0] step_rem;
    logic           step_bit;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .part_rem (rem_q),
        .next_bit (quo_q[WIDTH-1]),
        .divisor  (dvs_q),
        .new_rem  (step_rem),
        .q_bit    (step_bit)
    );

    // Sign correction applied in FIX.
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;

    assign fix_q = q_neg_q ? -quo_q : quo_q;
    assign fix_r = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    logic             hit;
    logic [WIDTH-1:0] hit_res;

`ifdef DIV_RESULT_CACHE_EN
    logic             c_valid;
    logic             c_sgn;
    logic [WIDTH-1:0] c_a;
    logic [WIDTH-1:0] c_b;
    logic [WIDTH-1:0] c_quo;
    logic [WIDTH-1:0] c_rem;
    logic [WIDTH-1:0] a_raw_q;    // raw operands of the op in flight, for the tag
    logic [WIDTH-1:0] b_raw_q;

    assign hit     = c_valid && (c_a == dividend) && (c_b == divisor) && (c_sgn == sgn);
    assign hit_res = is_rem(op_in) ? c_rem : c_quo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_sgn   <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_quo   <= '0;
            c_rem   <= '0;
            a_raw_q <= '0;
            b_raw_q <= '0;
        end else if (flush) begin
            c_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_raw_q <= dividend;
                b_raw_q <= divisor;
            end
            if (accept && !hit && (div_zero || ovf)) begin
                c_valid <= 1'b1;
                c_sgn   <= sgn;
                c_a     <= dividend;
                c_b     <= divisor;
                c_quo   <= special_q;
                c_rem   <= special_r;
            end else if (state == FIX) begin
                c_valid <= 1'b1;
                c_sgn   <= is_signed(op_q);
                c_a     <= a_raw_q;
                c_b     <= b_raw_q;
                c_quo   <= fix_q;
                c_rem   <= fix_r;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= DIV;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            // Flush wins over acceptance and over out_ready; result is dropped.
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_in;
                        if (hit) begin
                            result_q <= hit_res;
                            state    <= DONE;
                        end else if (div_zero || ovf) begin
                            result_q <= is_rem(op_in) ? special_r : special_q;
                            state    <= DONE;
                        end else begin
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            cnt_q   <= CNT_W'(WIDTH);
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[WIDTH-2:0], step_bit};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= is_rem(op_q) ? fix_r : fix_q;
                    state    <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;

endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised radix-2 iterative divider for the M-extension execute stage, replacing the fixed 32-bit divider. Supports DIV/DIVU/REM/REMU with RISC-V–compliant divide-by-zero and signed-overflow results. Uses a valid/ready handshake on both input and output sides, plus a pipeline flush. Computes on magnitudes with sign correction, so signed results are exact.

## Interface
- WIDTH, 32: operand/result width, ≥4
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived, not overridden)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  abort in-flight op, return to IDLE next edge
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  WIDTH  operand1
- divisor  in  WIDTH  operand2
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  quotient or remainder per op

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready; latch op and operands.
  - Signed ops store |dividend| and |divisor|, and record quotient sign = sign(a)^sign(b) and remainder sign = sign(a).
- Special cases are detected at accept and go directly to DONE, skipping CALC/FIX:
  - divisor==0: quotient = all-ones; remainder = dividend (unmodified).
  - Signed op with dividend = MIN (1 followed by zeros) and divisor = all-ones: quotient = MIN; remainder = 0.
- CALC: WIDTH iterations of restoring division on magnitudes.
  - Shift partial remainder (WIDTH+1 bits) left, taking in the next dividend MSB.
  - Subtract the divisor. If the result is non-negative, keep it and set quotient bit to 1; otherwise restore and set quotient bit to 0.
  - Counter counts WIDTH down to 1.
- FIX: for signed ops, negate the quotient and/or remainder (two's complement) per the recorded signs. Select the result per op.
- DONE: out_valid=1 and result is stable. On out_ready, go to IDLE on the next edge.
- flush: from any state, go to IDLE next edge and drop out_valid; the result is discarded. flush has priority over acceptance and over out_ready.
- An unsigned op with the divisor MSB set is valid and needs no special case.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, result=0, counter=0.
- Normal latency: out_valid rises WIDTH+2 cycles after the accept edge (WIDTH CALC + 1 FIX + registered DONE).
- Special-case latency: out_valid high 1 cycle after the accept edge.
- in_ready=0 from the accept edge until the cycle after out_valid&out_ready.
- No back-to-back overlap. Throughput: one op per WIDTH+3 cycles when out_ready is tied high.
- Operand and op inputs are ignored after the accept edge and may change freely.
- Reset mid-operation: all state is cleared immediately (asynchronous); no result emerges.

## Configuration
- DIV_RESULT_CACHE_EN:
  - Defined: store the last completed dividend, divisor, signedness, quotient and remainder.
  - An accepted request whose operands and signedness match the stored entry (e.g. DIV followed by REM) goes directly to DONE, with 1-cycle latency.
  - Cache is invalidated by rst and flush. Special-case results are also cached.
- Undefined: no cache storage; every non-special op takes the full latency.

## Structure
- div_pkg: typedef enum div_op_e {DIV, DIVU, REM, REMU}; typedef enum div_state_e {IDLE, CALC, FIX, DONE}; helper function is_signed(op).
- Sub-module div_restore_step (combinational), parameter WIDTH. Inputs: partial remainder, next dividend bit, divisor. Outputs: new remainder and quotient bit. Instantiated once.

## Test plan
- WIDTH=32, out_ready=1:
  - DIV 100/7 → 14.
  - REM 100/7 → 2.
  - out_valid exactly 34 cycles after accept.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; REMU 0x80000000/0x80000001 → 0x80000000.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Both with 1-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and result stable, in_ready=0. Then assert out_ready → in_ready=1 next cycle.
- Abort:
  - flush at CALC cycle 5 → IDLE next edge, out_valid never rises. Next op 9/3 → 3.
  - rst asserted mid-CALC → all outputs at reset values immediately.
- With DIV_RESULT_CACHE_EN: DIV 1000/33 → 30 (34 cycles), then REM 1000/33 → 10 (1 cycle). After a flush, the REM takes 34 cycles. WIDTH=8 regression: DIVU 200/7 → 28 in 10 cycles.
